// File: rtl/tt_lut_pkg.sv
// Shared types and sizing helpers for the truth-table LUT engine.
package tt_lut_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_LOAD,
    CFG_DROP
  } cfg_state_e;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned tt_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic int unsigned nbeat(input int unsigned n, input int unsigned cfg_w);
    return tt_w(n) / cfg_w;
  endfunction

endpackage

// File: rtl/tt_cfg_loader.sv
// Chunked table loader: collects config beats into a shadow table and flags commit/length error.
module tt_cfg_loader
  import tt_lut_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CFG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [CFG_W-1:0]        cfg_data,
  input  logic                    cfg_last,
  output logic                    cfg_ready,
  output logic                    cfg_err,
  output logic                    commit,
  output logic [tt_w(N_IN)-1:0]   shadow
);

  localparam int unsigned TT_W   = tt_w(N_IN);
  localparam int unsigned NBEAT  = nbeat(N_IN, CFG_W);
  localparam int unsigned CNT_BW = (NBEAT < 1) ? 1 : $clog2(NBEAT + 1);
  localparam logic [CNT_BW-1:0] NBEAT_C = CNT_BW'(NBEAT);
  localparam logic [CNT_BW-1:0] LAST_C  = CNT_BW'(NBEAT - 1);

  cfg_state_e        state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic              rdy_q;
  logic              err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    commit   = 1'b0;
    if (cfg_valid && rdy_q) begin
      unique case (state_q)
        CFG_IDLE, CFG_LOAD: begin
          for (int unsigned b = 0; b < NBEAT; b++) begin
            if (cnt_q == CNT_BW'(b)) begin
              shadow_d[b*CFG_W +: CFG_W] = cfg_data;
            end
          end
          if (cfg_last) begin
            cnt_d   = '0;
            state_d = CFG_IDLE;
            if (cnt_q == LAST_C) begin
              commit = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (cnt_q == NBEAT_C) begin
            // Overlong load: swallow the rest until cfg_last, then report it.
            state_d = CFG_DROP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = CFG_LOAD;
          end
        end
        CFG_DROP: begin
          if (cfg_last) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = CFG_IDLE;
          end
        end
        default: state_d = CFG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CFG_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rdy_q    <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign cfg_ready = rdy_q;
  assign cfg_err   = err_q;
  // Merged view so the final chunk lands in the same edge as the commit.
  assign shadow    = shadow_d;

endmodule

// File: rtl/tt_lut_engine.sv
// Runtime-loadable N-input truth-table evaluator with a one-deep output register.
// Optional handshake ones counter enabled by defining TT_LUT_COUNT_EN.
module tt_lut_engine
  import tt_lut_pkg::*;
#(
  parameter int unsigned            N_IN     = 4,
  parameter int unsigned            CFG_W    = 8,
  parameter logic [tt_w(N_IN)-1:0]  TT_RESET = 16'h429B
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_W-1:0]        cfg_data,
  input  logic                    cfg_last,
  output logic                    cfg_err,
`ifdef TT_LUT_COUNT_EN
  output logic [CNT_W-1:0]        ones_cnt,
`endif
  output logic [tt_w(N_IN)-1:0]   tt_active
);

  localparam int unsigned TT_W = tt_w(N_IN);

  logic            commit;
  logic [TT_W-1:0] shadow;
  logic [TT_W-1:0] tt_q;
  logic            out_valid_q;
  logic            out_data_q;
  logic            accept;

  tt_cfg_loader #(
    .N_IN  (N_IN),
    .CFG_W (CFG_W)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .commit    (commit),
    .shadow    (shadow)
  );

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Eval reads tt_q before the commit edge updates it, so a same-cycle commit sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      tt_q        <= TT_RESET;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= tt_q[in_data];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (commit) begin
        tt_q <= shadow;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tt_active = tt_q;

`ifdef TT_LUT_COUNT_EN
  logic [CNT_W-1:0] ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else if (commit) begin
      ones_q <= '0;
    end else if (out_valid_q && out_ready && out_data_q && (ones_q != '1)) begin
      ones_q <= ones_q + 1'b1;
    end
  end

  assign ones_cnt = ones_q;
`endif

endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed plus random bench for tt_lut_engine against a table/queue reference model.
module tb_tt_lut_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic        cfg_last;
  logic        cfg_err;
  logic [15:0] tt_active;
`ifdef TT_LUT_COUNT_EN
  logic [15:0] ones_cnt;
`endif

  always #5 clk = ~clk;

  tt_lut_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
`ifdef TT_LUT_COUNT_EN
    .ones_cnt  (ones_cnt),
`endif
    .tt_active (tt_active)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_known = 1'b0;
  logic        m_ov, m_od, m_rdy, m_err;
  logic [15:0] m_tt;
  logic [7:0]  beats[$];
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, advance the model by one edge, return just after the edge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("tt_active", 32'(tt_active), 32'(m_tt));
`ifdef TT_LUT_COUNT_EN
      chk("ones_cnt", 32'(ones_cnt), m_cnt);
`endif
    end
    if (rst) begin
      m_ov  = 1'b0;
      m_od  = 1'b0;
      m_rdy = 1'b0;
      m_err = 1'b0;
      m_tt  = 16'h429B;
      m_cnt = 0;
      beats.delete();
      m_known = 1'b1;
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      if (m_ov && out_ready && m_od && m_cnt != 32'hFFFF) m_cnt++;
      if (acc) begin
        m_od = m_tt[in_data];
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      m_err = 1'b0;
      if (cfg_valid && m_rdy) begin
        beats.push_back(cfg_data);
        if (cfg_last) begin
          if (beats.size() == 2) begin
            m_tt  = {beats[1], beats[0]};
            m_cnt = 0;
          end else begin
            m_err = 1'b1;
          end
          beats.delete();
        end
      end
      m_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_beat(input logic [7:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_table", 32'(tt_active), 32'h429B);

    // 1: stream 0, 2, 15, 1 with out_ready held
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 4'd0;  tick();
    in_data = 4'd2;  tick();
    in_data = 4'd15; tick();
    in_data = 4'd1;  tick();
    in_valid = 1'b0;
    tick();
    tick();

    // 2: back-pressure for three cycles, next vector waits
    in_valid = 1'b1; in_data = 4'd3; tick();
    out_ready = 1'b0; in_data = 4'd4;
    tick(); tick(); tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();

    // 3: load 8001, eval of 15 on the commit cycle sees the old table
    cfg_beat(8'h01, 1'b0);
    in_valid = 1'b1; in_data = 4'd15;
    cfg_beat(8'h80, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("commit_8001", 32'(tt_active), 32'h8001);

    // 4: short and long loads are rejected
    cfg_beat(8'h77, 1'b1);
    tick();
    cfg_beat(8'h11, 1'b0);
    cfg_beat(8'h22, 1'b0);
    cfg_beat(8'h33, 1'b1);
    tick();
    chk("bad_len_keep", 32'(tt_active), 32'h8001);

    // 5: reset mid-load with a result in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd0;
    cfg_beat(8'h55, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_table", 32'(tt_active), 32'h429B);
    tick();
    out_ready = 1'b1;
    cfg_beat(8'hAA, 1'b0);
    cfg_beat(8'h5A, 1'b1);
    tick();
    chk("reload_5aaa", 32'(tt_active), 32'h5AAA);

    // Random traffic on both channels
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_data  = 8'($urandom_range(0, 255));
      cfg_last  = ($urandom_range(0, 2) == 0);
      tick();
    end
    in_valid = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; out_ready = 1'b1;
    tick();
    cfg_beat(8'h00, 1'b1);
    tick();

`ifdef TT_LUT_COUNT_EN
    // 6: count ones handshakes, commit clears
    cfg_beat(8'hFF, 1'b0);
    cfg_beat(8'hFF, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("ones_five", 32'(ones_cnt), 32'd5);
    cfg_beat(8'h34, 1'b0);
    cfg_beat(8'h12, 1'b1);
    chk("ones_clear", 32'(ones_cnt), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
